// File: rtl/egress_arbiter.sv
// Packet-granular round-robin arbiter: shares one AXI-Stream egress port among
// NUM_REQ ingress streams, holding each grant from the first beat through tlast.
`timescale 1ns/1ps
module egress_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int DEST_W  = 2,
    parameter int PORT_ID = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        en,
    input  logic [NUM_REQ*DATA_W-1:0] s_tdata,
    input  logic [NUM_REQ*DEST_W-1:0] s_tdest,
    input  logic [NUM_REQ-1:0]        s_tvalid,
    input  logic [NUM_REQ-1:0]        s_tlast,
    output logic [NUM_REQ-1:0]        s_tready,
    output logic [DATA_W-1:0]         m_tdata,
    output logic                      m_tvalid,
    output logic                      m_tlast,
    input  logic                      m_tready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    input  logic                      clr_count,
    output logic [15:0]               pkt_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [DEST_W-1:0] PORT_DEST = DEST_W'(PORT_ID);
    localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
    logic                m_tvalid_q, m_tvalid_d;
    logic                m_tlast_q, m_tlast_d;
    logic [15:0]         pkt_count_q, pkt_count_d;

    logic [NUM_REQ-1:0]  req;
    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [IDX_W-1:0]    cand;
    logic                out_free;
    logic                accept;
    logic                last_accept;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i] = s_tvalid[i] & en[i] & (s_tdest[i*DEST_W +: DEST_W] == PORT_DEST);
        end
    end

    // Round-robin search starts just after the previous packet's owner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = last_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Ready depends only on state and the output register, never on s_tvalid.
    always_comb begin
        out_free = !m_tvalid_q | m_tready;
        s_tready = '0;
        if (state_q == LOCKED) begin
            s_tready[sel_q] = out_free;
        end
        accept      = (state_q == LOCKED) & s_tvalid[sel_q] & out_free;
        last_accept = accept & s_tlast[sel_q];
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        sel_d       = sel_q;
        grant_d     = grant_q;
        m_tdata_d   = m_tdata_q;
        m_tvalid_d  = m_tvalid_q;
        m_tlast_d   = m_tlast_q;
        pkt_count_d = pkt_count_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d          = LOCKED;
                    sel_d            = win_idx;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                end
            end
            LOCKED: begin
                if (last_accept) begin
                    state_d = IDLE;
                    last_d  = sel_q;
                    grant_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            m_tdata_d  = s_tdata[sel_q*DATA_W +: DATA_W];
            m_tlast_d  = s_tlast[sel_q];
            m_tvalid_d = 1'b1;
        end else if (m_tready) begin
            m_tvalid_d = 1'b0;
        end

        // Clear takes priority over a coincident increment.
        if (clr_count) begin
            pkt_count_d = '0;
        end else if (last_accept) begin
            pkt_count_d = pkt_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            last_q      <= LAST_RST;
            sel_q       <= '0;
            grant_q     <= '0;
            m_tdata_q   <= '0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            grant_q     <= grant_d;
            m_tdata_q   <= m_tdata_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign m_tdata   = m_tdata_q;
    assign m_tvalid  = m_tvalid_q;
    assign m_tlast   = m_tlast_q;
    assign grant     = grant_q;
    assign busy      = (state_q == LOCKED);
    assign pkt_count = pkt_count_q;

endmodule

// File: doc/egress_arbiter.md
# egress_arbiter

Packet-granular round-robin arbiter that shares one AXI-Stream egress port among `NUM_REQ` ingress streams. It sits between the per-port ingress filters and an egress port of the packet filter. Each requester presents `tdest`, and only packets addressed to this port (`tdest == PORT_ID`) from enabled requesters compete. A grant is held from the first beat through `tlast`, so packets never interleave on the egress port.

## Interface
- `NUM_REQ`, 4, number of requesting streams (2..8)
- `DATA_W`, 16, tdata width
- `DEST_W`, 2, tdest width
- `PORT_ID`, 0, tdest value this instance serves
- `clk`  input  1  single clock, all logic on rising edge
- `reset`  input  1  asynchronous, active-low reset
- `en`  input  NUM_REQ  per-requester enable (active-high), sampled only at arbitration
- `s_tdata`  input  NUM_REQ*DATA_W  requester i at bits [i*DATA_W +: DATA_W]
- `s_tdest`  input  NUM_REQ*DEST_W  requester i at bits [i*DEST_W +: DEST_W]
- `s_tvalid`  input  NUM_REQ  per-requester valid
- `s_tlast`  input  NUM_REQ  per-requester end of packet
- `s_tready`  output  NUM_REQ  per-requester ready
- `m_tdata`  output  DATA_W  egress data (registered)
- `m_tvalid`  output  1  egress valid (registered)
- `m_tlast`  output  1  egress end of packet (registered)
- `m_tready`  input  1  egress ready
- `grant`  output  NUM_REQ  one-hot current owner; 0 when idle
- `busy`  output  1  high in LOCKED state
- `clr_count`  input  1  synchronous clear of `pkt_count`
- `pkt_count`  output  16  packets forwarded (counted on the accepted tlast beat)

## Operation
- Request: `req[i] = s_tvalid[i] & en[i] & (s_tdest[i] == PORT_ID)`.
- State machine has two states:
  - IDLE -> LOCKED when any `req` is set. The winner is the first set `req` searching `last+1, last+2, …` modulo `NUM_REQ`. The `grant` register and `sel` are loaded on that edge.
  - LOCKED -> IDLE on the edge where the granted requester's beat with `s_tlast = 1` is accepted. `last <= sel` on the same edge.
- Readiness:
  - In LOCKED: `s_tready[sel] = !m_tvalid | m_tready`, and all other `s_tready` are 0.
  - In IDLE: all `s_tready` are 0.
- Beat accept is `s_tvalid[sel] & s_tready[sel]`. On accept, the output register loads `tdata`/`tlast` of `sel` and sets `m_tvalid`.
- The output register clears `m_tvalid` when `m_tready` is high and there is no new accept in the same cycle.
- Once locked, `en` and `tdest` changes are ignored until tlast. A disabled requester always finishes its current packet.
- `pkt_count` increments by 1 on each accepted tlast beat and wraps from 0xFFFF to 0x0000. When `clr_count` and an increment coincide, clear wins and the result is 0.
- `busy = (state == LOCKED)`.

## Timing
- Reset is asynchronous and applies immediately. Values while in reset:
  - state IDLE, `last = NUM_REQ-1` (requester 0 wins first)
  - `grant = 0`, `busy = 0`, `s_tready = 0`
  - `m_tvalid = 0`, `m_tdata = 0`, `m_tlast = 0`, `pkt_count = 0`
- Latency:
  - A request seen in cycle N gives `grant`/`busy` in N+1.
  - The first beat can be accepted in N+1 and appears on `m_*` in N+2.
- After a tlast accept there is one IDLE cycle, so back-to-back packets have a one-beat bubble.
- With `m_tready` held high, throughput inside a packet is one beat per cycle.
- With `m_tready` low and `m_tvalid` high, `m_tdata`/`m_tlast` hold stable and `s_tready[sel]` is 0.
- `s_tready` is combinational from state, `m_tvalid` and `m_tready`. It never depends on `s_tvalid`.
- A single-beat packet (tlast on the first beat) returns to IDLE on the edge after grant plus one.
- Reset asserted mid-packet discards the packet: the output register clears and there is no partial count. After reset is released, the requester must restart with a fresh packet.

## Test plan
- Single packet from requester 2 (`en = 4'hF`, `tdest = 0`, 3 beats 0xA001..0xA003, `m_tready = 1`):
  - `grant = 4'b0100` in cycle 1.
  - Beats appear on `m_*` in cycles 2-4, tlast on 0xA003.
  - `pkt_count = 1`.
- All four requesters hold 2-beat packets continuously:
  - Grant order is 0, 1, 2, 3, 0.
  - No interleaving; each packet has a one-cycle gap.
  - After 4 packets, `pkt_count = 4`.
- Backpressure: `m_tready` toggles 1,0,0,1 during a 4-beat packet.
  - Each beat is delivered exactly once, in order.
  - `m_tdata` is stable while stalled.
  - `s_tready[sel] = 0` in stall cycles.
- Filtering:
  - Requester 1 with `tdest = 2`, or `en[1] = 0`: never granted, `s_tready[1]` stays 0.
  - Clearing `en[3]` mid-packet: requester 3 completes its packet.
- Counter:
  - Preload to 0xFFFF via 65535 single-beat packets (or a force), then one more packet gives `pkt_count = 0`.
  - `clr_count` in the same cycle as a tlast accept gives 0.
- Reset while mid-packet (beat 2 of 4) gives:
  - `m_tvalid = 0`, `grant = 0`, `busy = 0` immediately.
  - After release, requester 0 wins first.
